// File: rtl/message_overlay_ctrl.sv
// Banner sequencer (drop-in, hold, release) and registered banner-rectangle generator.
// Define MSG_BLINK_EN to blink the resting banner every BLINK_FRAMES frames.
//
// state | meaning
// IDLE  | no banner, waiting for a game event
// DROP  | banner moving down DROP_STEP pixels per frame toward FINAL_Y
// HOLD  | banner at rest; game over waits for restartKey, others time out
module message_overlay_ctrl #(
    parameter int OBJECT_WIDTH_X = 280,
    parameter int OBJECT_HEIGHT_Y = 48,
    parameter int TOP_LEFT_X = 180,
    parameter int START_Y = 0,
    parameter int FINAL_Y = 216,
    parameter int DROP_STEP = 8,
    parameter int SHOW_FRAMES = 180,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        gameOverEvt,
    input  logic        levelDoneEvt,
    input  logic        winEvt,
    input  logic        restartKey,
    output logic [1:0]  message,
    output logic        InsideRectangle,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        msgActive,
    output logic        msgDone
);

    typedef enum logic [1:0] {ST_IDLE, ST_DROP, ST_HOLD} state_t;

    localparam logic [1:0] MSG_NONE  = 2'b00;
    localparam logic [1:0] MSG_LEVEL = 2'b01;
    localparam logic [1:0] MSG_OVER  = 2'b10;
    localparam logic [1:0] MSG_WIN   = 2'b11;
    localparam int CNT_W = $clog2(SHOW_FRAMES);
    localparam logic [10:0] X_LO = 11'(TOP_LEFT_X);
    localparam logic [11:0] X_HI = 12'(TOP_LEFT_X + OBJECT_WIDTH_X);
    localparam logic [10:0] Y_START = 11'(START_Y);
    localparam logic [11:0] Y_FINAL = 12'(FINAL_Y);

    state_t           state_q, state_d;
    logic [1:0]       code_q, code_d;
    logic [10:0]      top_y_q, top_y_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             msg_done_q, msg_done_d;
    logic             inside_q, inside_d;
    logic [10:0]      off_x_q, off_x_d;
    logic [10:0]      off_y_q, off_y_d;

    logic [1:0]  evt_code;
    logic        any_evt;
    logic [11:0] top_y_sum;
    logic [10:0] top_y_step;
    logic [11:0] y_end;
    logic        blank;
    logic        hit;

    assign message   = code_q;
    assign msgActive = (state_q != ST_IDLE);
    assign msgDone   = msg_done_q;
    assign InsideRectangle = inside_q;
    assign offsetX   = off_x_q;
    assign offsetY   = off_y_q;

    always_comb begin
        any_evt = gameOverEvt | winEvt | levelDoneEvt;
        if (gameOverEvt)
            evt_code = MSG_OVER;
        else if (winEvt)
            evt_code = MSG_WIN;
        else
            evt_code = MSG_LEVEL;
        top_y_sum  = {1'b0, top_y_q} + 12'(DROP_STEP);
        top_y_step = (top_y_sum > Y_FINAL) ? Y_FINAL[10:0] : top_y_sum[10:0];
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        top_y_d     = top_y_q;
        frame_cnt_d = frame_cnt_q;
        msg_done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_evt) begin
                    code_d  = evt_code;
                    top_y_d = Y_START;
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (gameOverEvt)
                    code_d = MSG_OVER;
                if (startOfFrame) begin
                    top_y_d = top_y_step;
                    if ({1'b0, top_y_step} == Y_FINAL) begin
                        frame_cnt_d = '0;
                        state_d     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (code_q == MSG_OVER) begin
                    if (restartKey) begin
                        code_d     = MSG_NONE;
                        top_y_d    = Y_START;
                        msg_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else if (gameOverEvt) begin
                    // topY is already at rest, so DROP hands back to HOLD on the next frame
                    code_d  = MSG_OVER;
                    state_d = ST_DROP;
                end else if (startOfFrame) begin
                    if (frame_cnt_q == CNT_W'(SHOW_FRAMES - 1)) begin
                        code_d     = MSG_NONE;
                        top_y_d    = Y_START;
                        msg_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef MSG_BLINK_EN
    localparam int BLK_W = $clog2(2 * BLINK_FRAMES);
    logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        if (state_q != ST_HOLD)
            blink_cnt_d = '0;
        else if (startOfFrame)
            blink_cnt_d = (blink_cnt_q == BLK_W'(2 * BLINK_FRAMES - 1)) ? '0 : blink_cnt_q + 1'b1;
        blank = (state_q == ST_HOLD) && (blink_cnt_q >= BLK_W'(BLINK_FRAMES));
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            blink_cnt_q <= '0;
        else
            blink_cnt_q <= blink_cnt_d;
    end
`else
    // no blinking: the window length only matters when blinking is built
    assign blank = (BLINK_FRAMES < 0);
`endif

    always_comb begin
        y_end = {1'b0, top_y_q} + 12'(OBJECT_HEIGHT_Y);
        hit = msgActive && !blank &&
              (pixelX >= X_LO) && ({1'b0, pixelX} < X_HI) &&
              (pixelY >= top_y_q) && ({1'b0, pixelY} < y_end);
        inside_d = hit;
        off_x_d  = hit ? (pixelX - X_LO) : 11'd0;
        off_y_d  = hit ? (pixelY - top_y_q) : 11'd0;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_IDLE;
            code_q      <= MSG_NONE;
            top_y_q     <= Y_START;
            frame_cnt_q <= '0;
            msg_done_q  <= 1'b0;
            inside_q    <= 1'b0;
            off_x_q     <= '0;
            off_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            top_y_q     <= top_y_d;
            frame_cnt_q <= frame_cnt_d;
            msg_done_q  <= msg_done_d;
            inside_q    <= inside_d;
            off_x_q     <= off_x_d;
            off_y_q     <= off_y_d;
        end
    end

endmodule

// File: tb/tb_message_overlay_ctrl.sv
// Self-checking bench for message_overlay_ctrl: short 8-cycle frames, random pixels,
// frame-level reference model of the banner life cycle.
module tb_message_overlay_ctrl;

    localparam int FL     = 8;
    localparam int FINAL  = 216;
    localparam int STEP   = 8;
    localparam int SHOW   = 180;
    localparam int BLINK  = 30;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        startOfFrame = 1'b0;
    logic        gameOverEvt = 1'b0;
    logic        levelDoneEvt = 1'b0;
    logic        winEvt = 1'b0;
    logic        restartKey = 1'b0;
    logic [1:0]  message;
    logic        InsideRectangle;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        msgActive;
    logic        msgDone;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    message_overlay_ctrl dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .gameOverEvt(gameOverEvt),
        .levelDoneEvt(levelDoneEvt), .winEvt(winEvt), .restartKey(restartKey),
        .message(message), .InsideRectangle(InsideRectangle),
        .offsetX(offsetX), .offsetY(offsetY), .msgActive(msgActive), .msgDone(msgDone)
    );

    // Reference model: phase 0 none, 1 falling, 2 resting; position from frames fallen.
    int m_phase, m_code, m_drops, m_rest, m_ox, m_oy;
    bit m_done, m_in;
    logic m_blank;

    function automatic int top_of(input int drops);
        int t;
        t = STEP * drops;
        return (t > FINAL) ? FINAL : t;
    endfunction

    always_comb begin
        m_blank = 1'b0;
`ifdef MSG_BLINK_EN
        if (m_phase == 2 && ((m_rest / BLINK) % 2 == 1)) m_blank = 1'b1;
`endif
    end

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_phase <= 0; m_code <= 0; m_drops <= 0; m_rest <= 0;
            m_done <= 0; m_in <= 0; m_ox <= 0; m_oy <= 0;
        end else begin
            m_done <= 0;
            if (m_phase != 0 && !m_blank && pixelX >= 180 && pixelX < 460 &&
                pixelY >= top_of(m_drops) && pixelY < top_of(m_drops) + 48) begin
                m_in <= 1; m_ox <= pixelX - 180; m_oy <= pixelY - top_of(m_drops);
            end else begin
                m_in <= 0; m_ox <= 0; m_oy <= 0;
            end
            case (m_phase)
                0: if (gameOverEvt || winEvt || levelDoneEvt) begin
                    m_phase <= 1; m_drops <= 0;
                    m_code <= gameOverEvt ? 2 : (winEvt ? 3 : 1);
                end
                1: begin
                    if (gameOverEvt) m_code <= 2;
                    if (startOfFrame) begin
                        m_drops <= m_drops + 1;
                        if (top_of(m_drops + 1) == FINAL) begin m_phase <= 2; m_rest <= 0; end
                    end
                end
                default: begin
                    if (startOfFrame) m_rest <= m_rest + 1;
                    if (m_code == 2) begin
                        if (restartKey) begin m_phase <= 0; m_code <= 0; m_done <= 1; end
                    end else if (gameOverEvt) begin
                        m_code <= 2; m_phase <= 1;
                    end else if (startOfFrame && m_rest == SHOW - 1) begin
                        m_phase <= 0; m_code <= 0; m_done <= 1;
                    end
                end
            endcase
        end
    end

    wire  [26:0] dut_obs = {message, msgActive, msgDone, InsideRectangle, offsetX, offsetY};
    logic [26:0] mdl_obs;
    always_comb mdl_obs = {2'(m_code), (m_phase != 0), m_done, m_in, 11'(m_ox), 11'(m_oy)};

    int obs_mism, obs_dones, obs_ins;

    task automatic cyc(input bit sof, input bit go, input bit win, input bit lvl, input bit rk,
                       input logic [10:0] px, input logic [10:0] py);
        startOfFrame = sof; gameOverEvt = go; winEvt = win; levelDoneEvt = lvl;
        restartKey = rk; pixelX = px; pixelY = py;
        @(posedge clk); #1;
        startOfFrame = 0; gameOverEvt = 0; winEvt = 0; levelDoneEvt = 0;
    endtask

    // Runs n frames of random pixels; optional events fire once in frame 0 at cycle ev_at.
    task automatic run_frames(input int n, input bit go, input bit win, input bit lvl,
                              input int ev_at, input bit rk);
        obs_mism = 0; obs_dones = 0; obs_ins = 0;
        for (int f = 0; f < n; f++) begin
            for (int c = 0; c < FL; c++) begin
                cyc(c == 0, go && f == 0 && c == ev_at, win && f == 0 && c == ev_at,
                    lvl && f == 0 && c == ev_at, rk,
                    11'($urandom_range(520, 140)), 11'($urandom_range(300, 0)));
                if (dut_obs !== mdl_obs) obs_mism++;
                obs_dones += int'(msgDone);
                obs_ins += int'(InsideRectangle);
            end
        end
    endtask

    task automatic test_reset();
        #2 resetN = 0;
        #1;
        n_checks++;
        if (dut_obs !== 27'd0) begin
            n_errors++; $display("FAIL reset_outputs: got %h expected 0", dut_obs);
        end
        @(posedge clk); @(posedge clk); #1 resetN = 1;
        run_frames(3, 0, 0, 0, -1, 0);
        n_checks++;
        if (obs_ins !== 0 || obs_mism !== 0 || msgActive !== 1'b0 || message !== 2'b00) begin
            n_errors++;
            $display("FAIL idle_frames: inside=%0d mism=%0d active=%b msg=%b expected 0 0 0 00",
                     obs_ins, obs_mism, msgActive, message);
        end
    endtask

    task automatic test_level_done();
        run_frames(1, 0, 0, 1, 2, 0);
        n_checks++;
        if (message !== 2'b01 || msgActive !== 1'b1) begin
            n_errors++; $display("FAIL level_load: msg=%b active=%b expected 01 1", message, msgActive);
        end
        run_frames(26, 0, 0, 0, -1, 0);
        n_checks++;
        if (obs_mism !== 0) begin
            n_errors++; $display("FAIL level_drop_model: mismatches=%0d expected 0", obs_mism);
        end
        cyc(0, 0, 0, 0, 0, 11'd180, 11'd208);
        cyc(0, 0, 0, 0, 0, 11'd180, 11'd207);
        n_checks++;
        if (InsideRectangle !== 1'b0) begin
            n_errors++; $display("FAIL level_top208_above: inside=%b expected 0", InsideRectangle);
        end
        run_frames(1, 0, 0, 0, -1, 0);
        cyc(0, 0, 0, 0, 0, 11'd180, 11'd216);
        n_checks++;
        if (InsideRectangle !== 1'b1 || offsetY !== 11'd0) begin
            n_errors++;
            $display("FAIL level_rest_top: inside=%b offY=%0d expected 1 0", InsideRectangle, offsetY);
        end
        run_frames(179, 0, 0, 0, -1, 0);
        n_checks++;
        if (obs_dones !== 0 || msgActive !== 1'b1 || obs_mism !== 0) begin
            n_errors++;
            $display("FAIL level_hold: dones=%0d active=%b mism=%0d expected 0 1 0",
                     obs_dones, msgActive, obs_mism);
        end
        run_frames(1, 0, 0, 0, -1, 0);
        n_checks++;
        if (obs_dones !== 1 || msgActive !== 1'b0 || message !== 2'b00) begin
            n_errors++;
            $display("FAIL level_release: dones=%0d active=%b msg=%b expected 1 0 00",
                     obs_dones, msgActive, message);
        end
    endtask

    task automatic test_priority_sticky();
        run_frames(1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 11'd180, 11'd0);
        n_checks++;
        if (message !== 2'b10 || InsideRectangle !== 1'b1 || offsetY !== 11'd0) begin
            n_errors++;
            $display("FAIL prio_load: msg=%b inside=%b offY=%0d expected 10 1 0",
                     message, InsideRectangle, offsetY);
        end
        run_frames(1000, 0, 1, 1, 4, 0);
        n_checks++;
        if (obs_dones !== 0 || message !== 2'b10 || obs_mism !== 0) begin
            n_errors++;
            $display("FAIL sticky_hold: dones=%0d msg=%b mism=%0d expected 0 10 0",
                     obs_dones, message, obs_mism);
        end
        cyc(0, 0, 0, 0, 1, 11'd0, 11'd0);
        n_checks++;
        if (msgDone !== 1'b1 || message !== 2'b00 || msgActive !== 1'b0) begin
            n_errors++;
            $display("FAIL sticky_restart: done=%b msg=%b active=%b expected 1 00 0",
                     msgDone, message, msgActive);
        end
        cyc(0, 0, 0, 0, 0, 11'd0, 11'd0);
        n_checks++;
        if (msgDone !== 1'b0) begin
            n_errors++; $display("FAIL sticky_done_width: done=%b expected 0", msgDone);
        end
    endtask

    task automatic test_preempt();
        run_frames(1, 0, 1, 0, 3, 0);
        run_frames(27, 0, 0, 0, -1, 0);
        run_frames(50, 0, 0, 0, -1, 0);
        n_checks++;
        if (message !== 2'b11 || obs_mism !== 0) begin
            n_errors++; $display("FAIL preempt_win_hold: msg=%b mism=%0d expected 11 0", message, obs_mism);
        end
        run_frames(1, 1, 0, 0, 3, 0);
        n_checks++;
        if (message !== 2'b10 || obs_dones !== 0) begin
            n_errors++; $display("FAIL preempt_code: msg=%b dones=%0d expected 10 0", message, obs_dones);
        end
        run_frames(1, 0, 0, 0, -1, 0);
        cyc(0, 0, 0, 0, 0, 11'd180, 11'd216);
        cyc(0, 0, 0, 0, 0, 11'd180, 11'd215);
        n_checks++;
        if (InsideRectangle !== 1'b0) begin
            n_errors++; $display("FAIL preempt_top_above: inside=%b expected 0", InsideRectangle);
        end
        run_frames(200, 0, 0, 0, -1, 0);
        n_checks++;
        if (obs_dones !== 0 || message !== 2'b10 || obs_mism !== 0) begin
            n_errors++;
            $display("FAIL preempt_no_release: dones=%0d msg=%b mism=%0d expected 0 10 0",
                     obs_dones, message, obs_mism);
        end
        cyc(0, 0, 0, 0, 1, 11'd0, 11'd0);
        cyc(0, 0, 0, 0, 0, 11'd0, 11'd0);
    endtask

    task automatic test_rect();
        logic [10:0] tx[7] = '{11'd180, 11'd459, 11'd460, 11'd179, 11'd300, 11'd300, 11'd300};
        logic [10:0] ty[7] = '{11'd216, 11'd263, 11'd263, 11'd240, 11'd264, 11'd215, 11'd240};
        logic [22:0] te[7] = '{{1'b1, 11'd0, 11'd0}, {1'b1, 11'd279, 11'd47}, 23'd0, 23'd0,
                               23'd0, 23'd0, {1'b1, 11'd120, 11'd24}};
        run_frames(1, 1, 0, 0, 5, 0);
        run_frames(27, 0, 0, 0, -1, 0);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 0, 0, 0, tx[i], ty[i]);
            n_checks++;
            if ({InsideRectangle, offsetX, offsetY} !== te[i]) begin
                n_errors++;
                $display("FAIL rect_%0d (x=%0d y=%0d): got in=%b ox=%0d oy=%0d expected in=%b ox=%0d oy=%0d",
                         i, tx[i], ty[i], InsideRectangle, offsetX, offsetY,
                         te[i][22], te[i][21:11], te[i][10:0]);
            end
        end
        cyc(0, 0, 0, 0, 1, 11'd0, 11'd0);
        cyc(0, 0, 0, 0, 0, 11'd0, 11'd0);
    endtask

    task automatic test_reset_mid();
        run_frames(1, 0, 0, 1, 2, 0);
        run_frames(12, 0, 0, 0, -1, 0);
        cyc(0, 0, 0, 0, 0, 11'd200, 11'd100);
        n_checks++;
        if (InsideRectangle !== 1'b1 || offsetY !== 11'd4) begin
            n_errors++;
            $display("FAIL mid_top96: inside=%b offY=%0d expected 1 4", InsideRectangle, offsetY);
        end
        #2 resetN = 0;
        #1;
        n_checks++;
        if (dut_obs !== 27'd0) begin
            n_errors++; $display("FAIL mid_async_reset: got %h expected 0", dut_obs);
        end
        @(posedge clk); #1 resetN = 1;
        run_frames(5, 0, 0, 0, -1, 0);
        n_checks++;
        if (obs_ins !== 0 || msgActive !== 1'b0 || obs_mism !== 0) begin
            n_errors++;
            $display("FAIL mid_after_reset: inside=%0d active=%b mism=%0d expected 0 0 0",
                     obs_ins, msgActive, obs_mism);
        end
    endtask

    task automatic test_random();
        int tot_mism = 0;
        int tot_dones = 0;
        int ev;
        for (int f = 0; f < 400; f++) begin
            ev = int'($urandom_range(15, 0));
            run_frames(1, ev == 0, ev == 1, ev == 2, int'($urandom_range(FL - 1, 0)),
                       $urandom_range(7, 0) == 0);
            tot_mism += obs_mism;
            tot_dones += obs_dones;
        end
        n_checks++;
        if (tot_mism !== 0) begin
            n_errors++; $display("FAIL random_model: mismatched cycles=%0d expected 0 (dones=%0d)",
                                 tot_mism, tot_dones);
        end
    endtask

    initial begin
        test_reset();
        test_level_done();
        test_priority_sticky();
        test_preempt();
        test_rect();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/message_overlay_ctrl.md
Name: message_overlay_ctrl

Overview:
- Upstream controller for the message bitmap stage (game-over / level / win banner).
- Latches game events, sequences the banner through drop-in, hold and release, and drives the `message` code.
- Generates the per-pixel `InsideRectangle` flag and `offsetX`/`offsetY` consumed by the bitmap stage.
- Sits between the game-logic event sources and the message bitmap stage, clocked by the VGA pixel clock.

Parameters:
- OBJECT_WIDTH_X, 280, banner width in pixels (70 bitmap columns x4).
- OBJECT_HEIGHT_Y, 48, banner height in pixels (12 bitmap rows x4).
- TOP_LEFT_X, 180, fixed banner left edge.
- START_Y, 0, banner top edge when the drop begins.
- FINAL_Y, 216, banner top edge at rest.
- DROP_STEP, 8, pixels moved down per frame during the drop.
- SHOW_FRAMES, 180, frames held for non-sticky messages.
- BLINK_FRAMES, 30, half-period of the blink (used only with the optional feature).

Ports:
- clk, input, 1, pixel clock.
- resetN, input, 1, asynchronous active-low reset.
- pixelX, input, 11, current scan X.
- pixelY, input, 11, current scan Y.
- startOfFrame, input, 1, one-cycle pulse at frame start.
- gameOverEvt, input, 1, one-cycle pulse.
- levelDoneEvt, input, 1, one-cycle pulse.
- winEvt, input, 1, one-cycle pulse.
- restartKey, input, 1, level; releases a sticky game-over.
- message, output, 2, code: 00 none, 01 level done, 10 game over, 11 win.
- InsideRectangle, output, 1, pixel lies inside the banner.
- offsetX, output, 11, pixelX - TOP_LEFT_X when inside, else 0.
- offsetY, output, 11, pixelY - topY when inside, else 0.
- msgActive, output, 1, high in any state other than IDLE.
- msgDone, output, 1, one-cycle pulse when a message is released.

Behaviour:
- Interface: one clock, `clk`; reset `resetN` is asynchronous, active-low.
- Reset values: state=IDLE, message=00, InsideRectangle=0, offsetX=0, offsetY=0, msgActive=0, msgDone=0, topY=START_Y, frame counter=0.
- States: IDLE, DROP, HOLD.
- IDLE:
  - Any event pulse loads the message code, sets topY=START_Y and moves to DROP.
  - Simultaneous events resolve by priority: gameOver (10) > win (11) > levelDone (01).
  - An event coinciding with startOfFrame does not step topY in that cycle.
- DROP: on each startOfFrame, topY = min(topY + DROP_STEP, FINAL_Y). When the new topY equals FINAL_Y, clear the frame counter and go to HOLD.
- HOLD, code 10 (game over):
  - Sticky; stays in HOLD until restartKey=1 is sampled.
  - Then: message=00, msgDone=1 for one cycle, topY=START_Y, go to IDLE.
- HOLD, other codes:
  - The frame counter increments on each startOfFrame.
  - When the counter reaches SHOW_FRAMES-1 and startOfFrame=1: release to IDLE with message=00 and a msgDone pulse.
- Preemption: gameOverEvt in DROP or HOLD with code != 10 overwrites the code with 10.
  - In HOLD this returns to DROP with topY unchanged, which then steps to HOLD on the next startOfFrame.
  - All other events outside IDLE are ignored (not queued).
- restartKey has no effect outside HOLD with code 10.
- Rectangle generation, registered with 1-cycle latency from pixelX/pixelY:
  - inside = msgActive && pixelX >= TOP_LEFT_X && pixelX < TOP_LEFT_X+OBJECT_WIDTH_X && pixelY >= topY && pixelY < topY+OBJECT_HEIGHT_Y.
  - Offsets are unsigned 11-bit and forced to 0 when not inside.
- Frame-synchronous position: topY updates only on startOfFrame, so the banner never tears mid-frame.
- message reflects the latched code during DROP/HOLD and 00 in IDLE.
- Reset mid-operation returns to the reset values immediately; a pending message is discarded.

Optional Feature:
- Macro: MSG_BLINK_EN.
- Defined:
  - In HOLD, a blink counter advances on startOfFrame.
  - InsideRectangle is forced to 0 during alternate BLINK_FRAMES-frame windows, starting visible on HOLD entry.
  - message and msgActive are unaffected.
  - DROP is never blanked.
- Undefined: no blink counter is built; the banner is continuously visible in HOLD.

Test Plan:
- Reset, then 3 frames with no events -> message=00, InsideRectangle=0 at every pixel, msgActive=0.
- levelDoneEvt, then 27 frames -> topY steps 0,8,...,216 and enters HOLD on frame 27; after 180 more frames message=00, a single-cycle msgDone, state IDLE.
- gameOverEvt and winEvt in the same cycle -> message=10. Then:
  - with restartKey=0, it holds for 1000 frames with no release;
  - restartKey=1 -> msgDone one cycle later, message=00.
- winEvt, HOLD reached, then gameOverEvt at HOLD frame 50 -> message=10, topY stays 216, no msgDone at frame 180.
- With banner at rest, drive pixelX=180,pixelY=216 -> next cycle InsideRectangle=1, offsets 0,0. Then:
  - pixelX=459,pixelY=263 -> offsets 279,47;
  - pixelX=460 -> InsideRectangle=0, offsets 0.
- Assert resetN low mid-DROP (topY=96) -> outputs zero asynchronously; after release, no banner until a new event. With MSG_BLINK_EN, HOLD frames 0-29 are visible and frames 30-59 are blanked.
